mips_bus_interface: RTL and testbench

- Memory-access stage between the multicycle MIPS datapath/decoder and the external Avalon-style memory bus.
- Accepts one load/store/fetch request at a time, drives address/read/write/byteenable/writedata, and holds the transaction while waitrequest is high.
- Returns lane-aligned, sign- or zero-extended read data, and holds a stall to the core until completion.
- Bus is little-endian: byte at addr[1:0]=0 is on data[7:0].

---
 rtl/mips_bus_interface.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_bus_interface.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_interface.sv
// mips_bus_interface
// Memory-access stage bridging the multicycle MIPS core to an Avalon-style,
// little-endian memory bus. One load/store/fetch is in flight at a time. The
// core is stalled while the bus transaction is open. Load data is returned
// lane-aligned and sign- or zero-extended.
//
// Optional feature: define MIPS_BUS_ALIGN_CHECK_EN to detect misaligned
// half/word requests. Such requests skip the bus and return resp_err=1 with
// zero data. When the macro is left undefined, the offending low address bits
// are silently truncated and resp_err stays 0.
module mips_bus_interface #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // core request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  // core response side
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  stall,
  output logic [WAIT_CNT_W-1:0] wait_cycles,
  // Avalon-style bus
  output logic [31:0]           address,
  output logic                  read,
  output logic                  write,
  input  logic                  waitrequest,
  output logic [31:0]           writedata,
  output logic [3:0]            byteenable,
  input  logic [31:0]           readdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Request fields captured at acceptance; only meaningful while BUS/RESP.
  logic [1:0]            off_p0;
  logic [1:0]            size_p0;
  logic                  signed_p0;
  logic                  wr_p0;

  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  accept;
  logic                  bus_done;
  logic                  misalign;

  // Byte-lane enables for an access of the given size at byte offset o.
  // A half only looks at o[1]; a word ignores o entirely.
  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] o);
    case (size)
      2'b00:   lane_be = 4'b0001 << o;
      2'b01:   lane_be = o[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across every lane it could land on, so the
  // byteenables alone select the written bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Pull the addressed byte/half out of the bus word and extend it to 32
  // bits. Words pass through untouched regardless of the signed flag.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic [1:0]  o,
                                               input logic        sgn,
                                               input logic [31:0] rdata);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    case (o)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = o[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00: begin
        if (sgn) load_extract = {{24{lane_b[7]}}, lane_b};
        else     load_extract = {24'd0, lane_b};
      end
      2'b01: begin
        if (sgn) load_extract = {{16{lane_h[15]}}, lane_h};
        else     load_extract = {16'd0, lane_h};
      end
      default: load_extract = rdata;
    endcase
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(
    input logic [WAIT_CNT_W-1:0] cnt);
    if (cnt == {WAIT_CNT_W{1'b1}}) sat_inc = cnt;
    else                           sat_inc = cnt + 1'b1;
  endfunction

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  // A half must sit on an even address, a word (and reserved size) on a
  // multiple of four. Bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] o);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = o[0];
      default: is_misaligned = (o != 2'b00);
    endcase
  endfunction

  assign misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign accept   = (state == IDLE) && req_valid;
  assign bus_done = (state == BUS) && !waitrequest;

  // State register; reset aborts any open transaction without a response.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded handshake/strobe outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    stall      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misalign ? RESP : BUS;
      end
      BUS: begin
        stall = 1'b1;
        read  = !wr_p0;
        write = wr_p0;
        if (!waitrequest) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: request capture at acceptance ----
  // Capture the request attributes needed later for lane extraction.
  always_ff @(posedge clk) begin
    if (accept) begin
      off_p0    <= req_addr[1:0];
      size_p0   <= req_size;
      signed_p0 <= req_signed;
      wr_p0     <= req_write;
    end
  end

`ifdef MIPS_BUS_ALIGN_CHECK_EN
  logic err_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // ---- bus phase and response capture ----
  // Bus address/lanes are set at acceptance and held; response fields are
  // loaded when the bus completes (or immediately for a rejected request).
  always_ff @(posedge clk) begin
    if (reset) begin
      address     <= 32'd0;
      writedata   <= 32'd0;
      byteenable  <= 4'd0;
      resp_rdata  <= 32'd0;
      wait_cycles <= '0;
      wait_cnt    <= '0;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        address    <= {req_addr[31:2], 2'b00};
        byteenable <= lane_be(req_size, req_addr[1:0]);
        writedata  <= lane_wdata(req_size, req_wdata);
        wait_cnt   <= '0;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
        if (misalign) begin
          resp_rdata  <= 32'd0;
          wait_cycles <= '0;
          err_q       <= 1'b1;
        end
`endif
      end
      if ((state == BUS) && waitrequest) begin
        wait_cnt <= sat_inc(wait_cnt);
      end
      if (bus_done) begin
        // Stores leave the previous load data in place.
        if (!wr_p0) resp_rdata <= load_extract(size_p0, off_p0, signed_p0, readdata);
        wait_cycles <= wait_cnt;
`ifdef MIPS_BUS_ALIGN_CHECK_EN
        err_q       <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_interface.sv
// Directed bench for mips_bus_interface: each transaction pushes its expected
// response onto a scoreboard queue, which is popped when resp_valid appears.
module tb_mips_bus_interface;

  localparam int WCW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [31:0]    req_addr;
  logic [1:0]     req_size;
  logic           req_signed;
  logic [31:0]    req_wdata;
  logic           resp_valid;
  logic [31:0]    resp_rdata;
  logic           resp_err;
  logic           stall;
  logic [WCW-1:0] wait_cycles;
  logic [31:0]    address;
  logic           read;
  logic           write;
  logic           waitrequest;
  logic [31:0]    writedata;
  logic [3:0]     byteenable;
  logic [31:0]    readdata;

  always #5 clk = ~clk;

  mips_bus_interface #(.WAIT_CNT_W(WCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .stall       (stall),
    .wait_cycles (wait_cycles),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata)
  );

  typedef struct {
    logic [31:0]    rdata;
    logic           err;
    logic [WCW-1:0] wc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, shape waitrequest for 'waits' cycles, then compare the
  // response against the scoreboard entry pushed at issue time.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input logic bus_exp,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic [WCW-1:0] exp_wc);
    exp_t e;
    int   k;
    int   rd_n;
    int   wr_n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.wc    = exp_wc;
    e.lat   = bus_exp ? waits + 2 : 1;
    sb.push_back(e);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (bus_exp) begin
      chk({tag, ".address"},    address, exp_addr);
      chk({tag, ".byteenable"}, {28'd0, byteenable}, {28'd0, exp_be});
      chk({tag, ".writedata"},  writedata, exp_wd);
      chk({tag, ".stall"},      {31'd0, stall}, 32'd1);
    end
    k = 0; rd_n = 0; wr_n = 0;
    while (!resp_valid && k < 40) begin
      rd_n += int'(read);
      wr_n += int'(write);
      waitrequest = (k < waits);
      readdata    = rdata;
      @(posedge clk); #1;
      k++;
    end
    waitrequest = 1'b0;
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    if (resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".latency"},     k + 1, e.lat);
      chk({tag, ".resp_rdata"},  resp_rdata, e.rdata);
      chk({tag, ".resp_err"},    {31'd0, resp_err}, {31'd0, e.err});
      chk({tag, ".wait_cycles"}, {30'd0, wait_cycles}, {30'd0, e.wc});
      chk({tag, ".stall_resp"},  {31'd0, stall}, 32'd0);
    end
    chk({tag, ".read_cycles"},  rd_n, (bus_exp && !wr) ? waits + 1 : 0);
    chk({tag, ".write_cycles"}, wr_n, (bus_exp && wr) ? waits + 1 : 0);
    @(posedge clk); #1;
    chk({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = 32'd0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_wdata   = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.read",        {31'd0, read}, 32'd0);
    chk("rst.write",       {31'd0, write}, 32'd0);
    chk("rst.address",     address, 32'd0);
    chk("rst.writedata",   writedata, 32'd0);
    chk("rst.byteenable",  {28'd0, byteenable}, 32'd0);
    chk("rst.resp_valid",  {31'd0, resp_valid}, 32'd0);
    chk("rst.resp_rdata",  resp_rdata, 32'd0);
    chk("rst.resp_err",    {31'd0, resp_err}, 32'd0);
    chk("rst.wait_cycles", {30'd0, wait_cycles}, 32'd0);
    chk("rst.stall",       {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst.req_ready",   {31'd0, req_ready}, 32'd1);

    run_txn("word_ld", 1'b0, 32'h0000_1004, 2'b10, 1'b0, 32'h0, 0, 32'hDEAD_BEEF,
            1'b1, 32'h0000_1004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'd0);
    run_txn("sbyte_ld", 1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0, 3, 32'h80FF_1234,
            1'b1, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0, 2'd3);
    run_txn("ubyte_ld", 1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0, 3, 32'h80FF_1234,
            1'b1, 32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 1'b0, 2'd3);
    run_txn("half_st", 1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_ABCD, 1, 32'h0,
            1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 1'b0, 2'd1);
    run_txn("byte_st", 1'b1, 32'h0000_3001, 2'b00, 1'b0, 32'h1234_5678, 0, 32'h0,
            1'b1, 32'h0000_3000, 4'b0010, 32'h7878_7878, 32'h0000_0080, 1'b0, 2'd0);
    run_txn("shalf_ld", 1'b0, 32'h0000_2002, 2'b01, 1'b1, 32'h0, 2, 32'h8001_7FFF,
            1'b1, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2'd2);
    run_txn("uhalf_ld", 1'b0, 32'h0000_2000, 2'b01, 1'b0, 32'h0, 0, 32'h8001_7FFF,
            1'b1, 32'h0000_2000, 4'b0011, 32'h0, 32'h0000_7FFF, 1'b0, 2'd0);
    run_txn("sbyte1_ld", 1'b0, 32'h0000_1001, 2'b00, 1'b1, 32'h0, 0, 32'h0000_9A00,
            1'b1, 32'h0000_1000, 4'b0010, 32'h0, 32'hFFFF_FF9A, 1'b0, 2'd0);
    run_txn("sat_ld", 1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0, 6, 32'h0123_4567,
            1'b1, 32'h0000_4000, 4'b1111, 32'h0, 32'h0123_4567, 1'b0, 2'd3);
`ifdef MIPS_BUS_ALIGN_CHECK_EN
    run_txn("misal_ld", 1'b0, 32'h0000_1002, 2'b10, 1'b0, 32'h0, 0, 32'hCAFE_F00D,
            1'b0, 32'h0, 4'b0000, 32'h0, 32'h0000_0000, 1'b1, 2'd0);
`else
    run_txn("misal_ld", 1'b0, 32'h0000_1002, 2'b10, 1'b0, 32'h0, 0, 32'hCAFE_F00D,
            1'b1, 32'h0000_1000, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 2'd0);
`endif

    // waitrequest activity while idle must not start anything
    waitrequest = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_wr.read",       {31'd0, read}, 32'd0);
    chk("idle_wr.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("idle_wr.req_ready",  {31'd0, req_ready}, 32'd1);
    waitrequest = 1'b0;
    @(posedge clk); #1;

    // reset in the second waitrequest cycle aborts without a response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_6000;
    req_size = 2'b10; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid   = 1'b0;
    waitrequest = 1'b1;
    chk("abort.read_b1", {31'd0, read}, 32'd1);
    @(posedge clk); #1;
    chk("abort.stall_b2", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.read",       {31'd0, read}, 32'd0);
    chk("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort.stall",      {31'd0, stall}, 32'd0);
    reset       = 1'b0;
    waitrequest = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      pulses += int'(resp_valid);
    end
    chk("abort.no_resp",   pulses, 0);
    chk("abort.req_ready", {31'd0, req_ready}, 32'd1);

    run_txn("word_st", 1'b1, 32'h0000_5000, 2'b10, 1'b0, 32'h1122_3344, 0, 32'h0,
            1'b1, 32'h0000_5000, 4'b1111, 32'h1122_3344, 32'h0000_0000, 1'b0, 2'd0);

    chk("sb.empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
